// File: rtl/seg_ser_rx.sv
// Receiver for a segment-driver serial link: collects FRAME_BITS bits clocked by SEGCLK,
// latches the frame on SEGEN and decodes three seven-segment glyphs into hex nibbles.
module seg_ser_rx #(
    parameter int FRAME_BITS = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  SEGCLK,
    input  logic                  SEGCLR,
    input  logic                  SEGDT,
    input  logic                  SEGEN,
    output logic [FRAME_BITS-1:0] frame,
    output logic                  frameValid,
    output logic                  frameErr,
    output logic [11:0]           digits,
    output logic [2:0]            digitErr
);

    localparam int CW = $clog2(FRAME_BITS + 2);
    localparam logic [CW-1:0] FULL_CNT = CW'(FRAME_BITS);
    localparam logic [CW-1:0] OVER_CNT = CW'(FRAME_BITS + 1);

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        FULL,
        OVER
    } state_t;

    // Synchronizer chains: bit 0 meets the pin, bit 2 is the edge-detect stage.
    logic [2:0] segclk_s;
    logic [2:0] segclr_s;
    logic [2:0] segdt_s;
    logic [2:0] segen_s;
    logic       clk_evt;
    logic       en_evt;
    logic       clr_act;
    logic       dt;

    state_t                state;
    state_t                state_nxt;
    logic [CW-1:0]         cnt;
    logic [CW-1:0]         cnt_nxt;
    logic [FRAME_BITS-1:0] shreg;
    logic [FRAME_BITS-1:0] shreg_nxt;
    logic [FRAME_BITS-1:0] frame_nxt;
    logic                  valid_nxt;
    logic                  err_nxt;

    // The event flops are registered from stages 1/2, so after each edge they line up
    // with stage 2 of SEGCLR and SEGDT, which therefore describe the same pin sample.
    // NOTE: every clocked register uses <= so all flops see pre-edge values of each other.
    always_ff @(posedge clk) begin
        if (rst) begin
            segclk_s <= 3'b000;
            segclr_s <= 3'b111;
            segdt_s  <= 3'b000;
            segen_s  <= 3'b000;
            clk_evt  <= 1'b0;
            en_evt   <= 1'b0;
        end else begin
            segclk_s <= {segclk_s[1:0], SEGCLK};
            segclr_s <= {segclr_s[1:0], SEGCLR};
            segdt_s  <= {segdt_s[1:0], SEGDT};
            segen_s  <= {segen_s[1:0], SEGEN};
            clk_evt  <= segclk_s[1] & ~segclk_s[2];
            en_evt   <= segen_s[1] & ~segen_s[2];
        end
    end

    assign clr_act = ~segclr_s[2];
    assign dt      = segdt_s[2];

    // NOTE: every variable gets a default before any branch, so no latch is inferred.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        shreg_nxt = shreg;
        frame_nxt = frame;
        valid_nxt = 1'b0;
        err_nxt   = 1'b0;
        if (clr_act) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            shreg_nxt = '0;
        end else begin
            if (clk_evt) begin
                shreg_nxt = {shreg[FRAME_BITS-2:0], dt};
                if (cnt != OVER_CNT) begin
                    cnt_nxt = cnt + 1'b1;
                end
                unique case (state)
                    IDLE, RECV: state_nxt = (cnt_nxt == FULL_CNT) ? FULL : RECV;
                    FULL:       state_nxt = OVER;
                    OVER:       state_nxt = OVER;
                endcase
            end
            // A strobe in the same cycle as a shift is judged after that shift.
            if (en_evt) begin
                if (state_nxt == FULL) begin
                    frame_nxt = shreg_nxt;
                    valid_nxt = 1'b1;
                end else begin
                    err_nxt = 1'b1;
                end
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            shreg      <= '0;
            frame      <= '1;
            frameValid <= 1'b0;
            frameErr   <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            shreg      <= shreg_nxt;
            frame      <= frame_nxt;
            frameValid <= valid_nxt;
            frameErr   <= err_nxt;
        end
    end

    // Active-low gfedcba pattern to {error, nibble}; dp is never looked at.
    function automatic logic [4:0] decode_glyph(input logic [6:0] seg);
        logic [4:0] res;
        case (seg)
            7'h40:   res = 5'h00;
            7'h79:   res = 5'h01;
            7'h24:   res = 5'h02;
            7'h30:   res = 5'h03;
            7'h19:   res = 5'h04;
            7'h12:   res = 5'h05;
            7'h02:   res = 5'h06;
            7'h78:   res = 5'h07;
            7'h00:   res = 5'h08;
            7'h10:   res = 5'h09;
            7'h08:   res = 5'h0A;
            7'h03:   res = 5'h0B;
            7'h46:   res = 5'h0C;
            7'h21:   res = 5'h0D;
            7'h06:   res = 5'h0E;
            7'h0E:   res = 5'h0F;
            default: res = 5'h10;
        endcase
        return res;
    endfunction

    // frameValid marks the cycle frame was loaded, so the decode lands one clk later.
    always_ff @(posedge clk) begin
        if (rst) begin
            digits   <= '0;
            digitErr <= '0;
        end else if (frameValid) begin
            {digitErr[0], digits[3:0]}  <= decode_glyph(frame[6:0]);
            {digitErr[1], digits[7:4]}  <= decode_glyph(frame[14:8]);
            {digitErr[2], digits[11:8]} <= decode_glyph(frame[22:16]);
        end
    end

endmodule

// File: doc/seg_ser_rx.md
SEG_SER_RX -- requirements
Module: seg_ser_rx

Interface
REQ-001 SHALL have parameter FRAME_BITS, default 64: number of SEGCLK rising edges in one complete frame.
REQ-002 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port SEGCLK  input  1  serial shift clock, asynchronous to clk.
REQ-005 SHALL have port SEGCLR  input  1  shift-chain clear, active-low.
REQ-006 SHALL have port SEGDT  input  1  serial data, stable at each SEGCLK rising edge.
REQ-007 SHALL have port SEGEN  input  1  frame latch strobe; its rising edge ends a frame.
REQ-008 SHALL have port frame  output  FRAME_BITS  last good frame; the first bit received is at frame[FRAME_BITS-1].
REQ-009 SHALL have port frameValid  output  1  one-clk pulse when frame updates.
REQ-010 SHALL have port frameErr  output  1  one-clk pulse when a frame is discarded.
REQ-011 SHALL have port digits  output  12  three hex nibbles decoded from frame[22:0].
REQ-012 SHALL have port digitErr  output  3  per-digit flag: segment pattern not a hex glyph.

Function
REQ-013 SHALL pass SEGCLK, SEGCLR, SEGDT and SEGEN through 2-flop synchronizers, then through a third stage used for edge detection.
REQ-014 SHALL define the SEGCLK and SEGEN events as synchronized 0->1 transitions; SEGCLR is active in each cycle its synchronized value is 0.
REQ-015 SHALL have an FSM with states IDLE (count 0), RECV (1..FRAME_BITS-1), FULL (count == FRAME_BITS) and OVER (count > FRAME_BITS).
REQ-016 SHALL, on each SEGCLK event, shift synchronized SEGDT into the shift register LSB and increment a saturating bit counter: IDLE->RECV, RECV->FULL at FRAME_BITS, FULL->OVER on the next event.
REQ-017 SHALL, on a SEGEN event in FULL, copy the shift register to frame, pulse frameValid and return to IDLE.
REQ-018 SHALL, on a SEGEN event in IDLE, RECV or OVER, leave frame unchanged, pulse frameErr and return to IDLE.
REQ-019 SHALL assert frameValid or frameErr exactly 3 clk cycles after the first clk edge that samples SEGEN high at the pin.
REQ-020 SHALL give SEGCLR priority over a same-cycle SEGCLK or SEGEN event: shift register and counter clear, state goes to IDLE, no pulse is generated.
REQ-021 SHALL, when SEGCLK and SEGEN events fall in the same cycle, apply the shift first and judge the SEGEN event on the updated count.
REQ-022 SHALL decode byte k (frame[8k+6:8k], k = 0..2) into digits[4k+3:4k], ignoring bit 8k+7 (dp).
REQ-023 SHALL use this active-low gfedcba glyph table: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E (hex).
REQ-024 SHALL, for a pattern not in the glyph table, output nibble 0 and set the digitErr bit for that digit.
REQ-025 SHALL register digits and digitErr so they update one clk after frame updates.

Reset
REQ-026 SHALL, while rst is high, set frame to all ones (blank), digits to 0, digitErr to 0, frameValid and frameErr to 0, state to IDLE, counter to 0, and all synchronizer stages to SEGCLK=0, SEGCLR=1, SEGDT=0, SEGEN=0.
REQ-027 SHALL abandon a frame in progress at reset without a pulse, and receive the next frame normally once rst falls.
REQ-028 SHALL give rst priority over every other input.

Verification
REQ-029 SHALL cover this case: send 64 bits of 0x12_46_40_08_06_79_24_30, then a SEGEN pulse -> frameValid once, frame equals that value, digits=0x123 and digitErr=0 one cycle later.
REQ-030 SHALL cover this case: send 63 bits, then SEGEN -> frameErr once and frame keeps its previous value.
REQ-031 SHALL cover this case: send 65 bits, then SEGEN -> frameErr once; a following clean 64-bit frame is accepted.
REQ-032 SHALL cover this case: hold SEGCLR low after 30 bits, then send a full 64-bit frame -> frameValid, with no leftover bits from the first 30.
REQ-033 SHALL cover this case: a frame whose low byte is 0xFF -> digits[3:0]=0 and digitErr[0]=1.
REQ-034 SHALL cover this case: assert rst during bit 40, then send a clean frame -> no pulse during reset, and the clean frame is accepted.
